// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer handlers.
// The Gray helpers work on a 32-bit container: zero-extending a narrower
// pointer leaves both conversions exact, so one function pair serves every
// pointer width up to 32 bits (truncate the result back to the pointer width).
package fifo_pkg;

   localparam int ADDR_SIZE_DEF = 4;

   // Number of FIFO entries for a given address width.
   function automatic int fifo_depth(input int addr_size);
      return 1 << addr_size;
   endfunction

   localparam int DEPTH = fifo_depth(ADDR_SIZE_DEF);

   // Binary to reflected Gray code.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Reflected Gray code to binary: XOR prefix from the MSB down.
   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter. Each binary bit is the XOR of the
// Gray bits at and above its position. Shared by the write- and read-side
// pointer handlers.
module gray2bin_conv #(
   parameter int W = 5
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);

   // Prefix XOR, one reduction per output bit (no chained feedback).
   for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin[i] = ^gray[W-1:i];
   end

endmodule

// File: rtl/wptr_handler_prog.sv
// Write-domain pointer handler for the asynchronous FIFO.
// Holds the binary/Gray write pointers, the registered full flag, the
// write-side occupancy count, a programmable almost-full flag and a sticky
// overflow flag. wq2_rptr must already be synchronised into wclk.
//
// Write handshake: winc is the request and ~wfull is the ready. A write
// transfers on a rising wclk edge exactly when winc & ~wfull; a request
// while wfull=1 is dropped (pointers untouched) and latches wovf.
module wptr_handler_prog
   import fifo_pkg::*;
#(
   parameter int ADDR_SIZE = 4
) (
   input  logic                 wclk,
   input  logic                 wrst_n,
   input  logic                 winc,
   input  logic [ADDR_SIZE:0]   wq2_rptr,
   input  logic [ADDR_SIZE:0]   afull_thresh,
   input  logic                 ovf_clr,
   output logic [ADDR_SIZE-1:0] waddr,
   output logic [ADDR_SIZE:0]   wptr,
   output logic                 wfull,
   output logic                 walmost_full,
   output logic [ADDR_SIZE:0]   wcount,
   output logic                 wovf
);

   localparam int PTR_W = ADDR_SIZE + 1;

   logic [ADDR_SIZE:0] wbin;
   logic [ADDR_SIZE:0] wbin_next;
   logic [ADDR_SIZE:0] wgray_next;
   logic [ADDR_SIZE:0] rbin_s;
   logic [ADDR_SIZE:0] count_next;
   logic               wr_ok;
   logic               full_next;
   logic               afull_next;

   gray2bin_conv #(.W(PTR_W)) u_rptr_conv (
      .gray (wq2_rptr),
      .bin  (rbin_s)
   );

   // Next pointers and occupancy; the synchronised read pointer lags, so
   // count_next can only over-report what is really stored.
   always_comb begin
      wr_ok      = winc & ~wfull;
      wbin_next  = wbin + {{ADDR_SIZE{1'b0}}, wr_ok};
      wgray_next = PTR_W'(bin2gray(32'(wbin_next)));
      count_next = wbin_next - rbin_s;
      afull_next = (count_next >= afull_thresh);
   end

   // Full when the write pointer is one lap ahead: in Gray this means the
   // two MSBs are inverted and the remaining bits equal.
   if (ADDR_SIZE == 1) begin : g_full_narrow
      assign full_next = (wgray_next == ~wq2_rptr);
   end else begin : g_full_wide
      assign full_next = (wgray_next == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1],
                                         wq2_rptr[ADDR_SIZE-2:0]});
   end

   // Pointer, count and flag registers, all updated from the same next values.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin         <= '0;
         wptr         <= '0;
         wcount       <= '0;
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
      end else begin
         wbin         <= wbin_next;
         wptr         <= wgray_next;
         wcount       <= count_next;
         wfull        <= full_next;
         walmost_full <= afull_next;
      end
   end

   // Sticky overflow: a dropped write sets it, and setting beats clearing.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wovf <= 1'b0;
      end else if (winc && wfull) begin
         wovf <= 1'b1;
      end else if (ovf_clr) begin
         wovf <= 1'b0;
      end
   end

   assign waddr = wbin[ADDR_SIZE-1:0];

endmodule

// File: tb/tb_wptr_handler_prog.sv
// Directed bench for wptr_handler_prog with ADDR_SIZE=4 (DEPTH=16).
module tb_wptr_handler_prog;

   logic       wclk;
   logic       wrst_n;
   logic       winc;
   logic [4:0] wq2_rptr;
   logic [4:0] afull_thresh;
   logic       ovf_clr;
   logic [3:0] waddr;
   logic [4:0] wptr;
   logic       wfull;
   logic       walmost_full;
   logic [4:0] wcount;
   logic       wovf;

   int n_cmp  = 0;
   int n_fail = 0;

   wptr_handler_prog #(.ADDR_SIZE(4)) dut (
      .wclk         (wclk),
      .wrst_n       (wrst_n),
      .winc         (winc),
      .wq2_rptr     (wq2_rptr),
      .afull_thresh (afull_thresh),
      .ovf_clr      (ovf_clr),
      .waddr        (waddr),
      .wptr         (wptr),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wcount       (wcount),
      .wovf         (wovf)
   );

   // Clock
   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   // Gray codes of binary 1..16
   logic [4:0] g_tab [16] = '{5'b00001, 5'b00011, 5'b00010, 5'b00110,
                              5'b00111, 5'b00101, 5'b00100, 5'b01100,
                              5'b01101, 5'b01111, 5'b01110, 5'b01010,
                              5'b01011, 5'b01001, 5'b01000, 5'b11000};

   // Wrap steps starting at wbin=27, rbin=17: {winc, wq2_rptr, wptr, wcount}
   typedef struct packed {
      logic       inc;
      logic [4:0] rptr;
      logic [4:0] exp_ptr;
      logic [4:0] exp_cnt;
   } wrap_step_t;

   wrap_step_t wrap_tab [8] = '{
      '{1'b1, 5'b11001, 5'b10010, 5'd11},  // wbin 28, rbin 17
      '{1'b0, 5'b11010, 5'b10010, 5'd9 },  // rbin 19
      '{1'b1, 5'b11010, 5'b10011, 5'd10},  // wbin 29
      '{1'b1, 5'b11111, 5'b10001, 5'd9 },  // wbin 30, rbin 21
      '{1'b1, 5'b11111, 5'b10000, 5'd10},  // wbin 31
      '{1'b1, 5'b10100, 5'b00000, 5'd8 },  // wbin 0, rbin 24
      '{1'b1, 5'b10001, 5'b00001, 5'd3 },  // wbin 1, rbin 30
      '{1'b1, 5'b00011, 5'b00011, 5'd0 }   // wbin 2, rbin 2
   };

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".waddr"}, 32'(waddr), 0);
      chk({tag, ".wptr"}, 32'(wptr), 0);
      chk({tag, ".wcount"}, 32'(wcount), 0);
      chk({tag, ".wfull"}, 32'(wfull), 0);
      chk({tag, ".walmost_full"}, 32'(walmost_full), 0);
      chk({tag, ".wovf"}, 32'(wovf), 0);
   endtask

   logic [4:0] prev_ptr;

   initial begin
      wrst_n       = 1'b1;
      winc         = 1'b0;
      wq2_rptr     = 5'b00000;
      afull_thresh = 5'd12;
      ovf_clr      = 1'b0;
      #1 wrst_n = 1'b0;
      #2;
      chk_all_zero("reset");

      // Release and confirm nothing moves without a write
      tick();
      wrst_n = 1'b1;
      tick();
      chk("idle.wcount", 32'(wcount), 0);

      // Fill with 16 writes, no reads
      winc = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk($sformatf("fill%0d.wptr", k), 32'(wptr), 32'(g_tab[k-1]));
         chk($sformatf("fill%0d.wcount", k), 32'(wcount), 32'(k));
         chk($sformatf("fill%0d.wfull", k), 32'(wfull), (k == 16) ? 1 : 0);
         chk($sformatf("fill%0d.afull", k), 32'(walmost_full), (k >= 12) ? 1 : 0);
      end

      // Writes while full are dropped and set overflow
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("ovf%0d.wptr", k), 32'(wptr), 32'h18);
         chk($sformatf("ovf%0d.wcount", k), 32'(wcount), 16);
         chk($sformatf("ovf%0d.wovf", k), 32'(wovf), 1);
      end
      ovf_clr = 1'b1;
      tick();
      chk("ovf_clr_with_winc.wovf", 32'(wovf), 1);
      winc = 1'b0;
      tick();
      chk("ovf_clr_alone.wovf", 32'(wovf), 0);
      ovf_clr = 1'b0;

      // One read seen from full
      wq2_rptr = 5'b00001;
      tick();
      chk("read1.wfull", 32'(wfull), 0);
      chk("read1.wcount", 32'(wcount), 15);
      chk("read1.afull", 32'(walmost_full), 1);
      winc = 1'b1;
      tick();
      chk("refill.wptr", 32'(wptr), 32'h19);
      chk("refill.wcount", 32'(wcount), 16);
      chk("refill.wfull", 32'(wfull), 1);
      chk("refill.waddr", 32'(waddr), 1);

      // Drain to empty (rbin 17) then write 10 with the read pointer held
      winc     = 1'b0;
      wq2_rptr = 5'b11001;
      tick();
      chk("drain.wcount", 32'(wcount), 0);
      chk("drain.wfull", 32'(wfull), 0);
      winc = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      chk("pre_wrap.wcount", 32'(wcount), 10);
      chk("pre_wrap.wptr", 32'(wptr), 32'h16);

      // Wrap across 31 -> 0 with the read pointer advancing
      prev_ptr = wptr;
      for (int k = 0; k < 8; k++) begin
         winc     = wrap_tab[k].inc;
         wq2_rptr = wrap_tab[k].rptr;
         tick();
         chk($sformatf("wrap%0d.wptr", k), 32'(wptr), 32'(wrap_tab[k].exp_ptr));
         chk($sformatf("wrap%0d.wcount", k), 32'(wcount), 32'(wrap_tab[k].exp_cnt));
         chk($sformatf("wrap%0d.wfull", k), 32'(wfull), 0);
         chk($sformatf("wrap%0d.bits_changed", k), 32'($countones(wptr ^ prev_ptr)),
             wrap_tab[k].inc ? 1 : 0);
         prev_ptr = wptr;
      end

      // Threshold 0: almost-full even when empty
      winc         = 1'b0;
      afull_thresh = 5'd0;
      tick();
      chk("thr0.wcount", 32'(wcount), 0);
      chk("thr0.afull", 32'(walmost_full), 1);

      // Threshold 17: never almost-full, even when full
      afull_thresh = 5'd17;
      winc         = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk($sformatf("thr17_%0d.afull", k), 32'(walmost_full), 0);
      end
      chk("thr17.wfull", 32'(wfull), 1);
      chk("thr17.wcount", 32'(wcount), 16);
      chk("thr17.wptr", 32'(wptr), 32'h1b);

      // Threshold 16 at full: takes effect on the next edge
      winc         = 1'b0;
      afull_thresh = 5'd16;
      tick();
      chk("thr16.afull", 32'(walmost_full), 1);

      // Set overflow again so reset has something to clear
      winc = 1'b1;
      tick();
      chk("ovf2.wovf", 32'(wovf), 1);
      chk("ovf2.wptr", 32'(wptr), 32'h1b);

      // Bring occupancy to 9, then reset between edges
      winc         = 1'b0;
      afull_thresh = 5'd12;
      wq2_rptr     = 5'b01101;
      tick();
      chk("pre_rst.wcount", 32'(wcount), 9);
      chk("pre_rst.wovf", 32'(wovf), 1);
      #2 wrst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");

      // First write after release
      wq2_rptr = 5'b00000;
      #2 wrst_n = 1'b1;
      winc = 1'b1;
      tick();
      chk("post_rst.waddr", 32'(waddr), 1);
      chk("post_rst.wcount", 32'(wcount), 1);
      chk("post_rst.wptr", 32'(wptr), 1);
      winc = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/wptr_handler_prog.md
# wptr_handler_prog

Write-domain pointer handler for the asynchronous FIFO, generalised from the basic write-pointer handler. It keeps the binary and Gray write pointers and registers the full flag. It adds a write-side occupancy count, a programmable almost-full flag and a sticky overflow flag. It sits in the write clock domain, between the write-side logic and the FIFO memory, and takes the 2-flop-synchronised Gray read pointer as input.

## Interface
- ADDR_SIZE, 4, address width; DEPTH = 2**ADDR_SIZE entries; pointers are ADDR_SIZE+1 bits
- wclk  in  1  write clock; all state changes on its rising edge
- wrst_n  in  1  asynchronous, active-low reset
- winc  in  1  write request; honoured only when wfull=0
- wq2_rptr  in  ADDR_SIZE+1  Gray read pointer, already synchronised to wclk
- afull_thresh  in  ADDR_SIZE+1  almost-full threshold, in entries (unsigned); treated as quasi-static
- ovf_clr  in  1  clears wovf
- waddr  out  ADDR_SIZE  memory write address, equal to wbin[ADDR_SIZE-1:0]
- wptr  out  ADDR_SIZE+1  registered Gray write pointer, sent to the read-side synchroniser
- wfull  out  1  registered full flag
- walmost_full  out  1  registered flag; set when occupancy >= afull_thresh
- wcount  out  ADDR_SIZE+1  registered occupancy as seen from the write side, range 0..DEPTH
- wovf  out  1  sticky overflow flag

## Operation
- Accepted write: wr_ok = winc & ~wfull. wbin_next = wbin + wr_ok, modulo 2**(ADDR_SIZE+1).
- Next Gray pointer: wgray_next = wbin_next ^ (wbin_next >> 1).
- Read pointer in binary: rbin_s = gray2bin(wq2_rptr), computed combinationally by XOR prefix from the MSB down.
- Next occupancy: count_next = wbin_next - rbin_s, modulo 2**(ADDR_SIZE+1). The result is always in 0..DEPTH.
- Full:
  - full_next = (wgray_next == {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]}).
  - This must agree with count_next == DEPTH.
  - For ADDR_SIZE=1, the low slice is empty; compare only the two MSBs.
- Almost-full:
  - afull_next = (count_next >= afull_thresh), unsigned, ADDR_SIZE+1 bits.
  - afull_thresh=0 → always 1.
  - afull_thresh > DEPTH → never 1.
- Overflow:
  - wovf sets when winc & wfull.
  - wovf clears on ovf_clr.
  - Set and clear in the same cycle → set wins.
  - A rejected write leaves wbin and wptr unchanged.
- Registered on each wclk edge: {wbin, wptr} <= {wbin_next, wgray_next}; wfull <= full_next; walmost_full <= afull_next; wcount <= count_next.
- Pessimism: wq2_rptr lags the true read pointer by the synchroniser latency.
  - wcount and both flags may over-report occupancy; they never under-report it.
  - wfull may stay set for extra cycles after reads; it never deasserts early.
- wptr changes by at most one bit per wclk cycle, including across the wrap from 2**(ADDR_SIZE+1)-1 to 0.

## Timing
- Reset (wrst_n=0, asynchronous): wbin, wptr, waddr, wcount = 0; wfull = walmost_full = wovf = 0.
  - Deassertion takes effect on the next wclk edge.
- Reset mid-operation: all state goes to 0 immediately. No partial update occurs.
- Write latency: a write accepted at edge N shows on waddr, wptr and wcount after edge N.
- Flag latency:
  - wfull and walmost_full update at the same edge as the write that causes them.
  - Example: the DEPTH-th write with no reads sets wfull at that same edge.
- Read-side changes: a change on wq2_rptr before edge N updates wcount and the flags at edge N.
- Simultaneous write and read-pointer change: both are folded into count_next in the same cycle.
- afull_thresh change: takes effect at the next edge.

## Structure
- Package fifo_pkg holds:
  - functions bin2gray and gray2bin, parameterised by width;
  - localparam DEPTH derivation.
- One sub-module: gray2bin_conv. It is combinational, width ADDR_SIZE+1, and converts wq2_rptr. It is reused later by the read-side handler.
- The top level holds the pointer registers, count/flag registers and the overflow logic.

## Test plan
All scenarios use ADDR_SIZE=4.
- Reset then 16 writes, wq2_rptr=0:
  - wptr steps through Gray 0,1,3,2,6,…;
  - wcount reaches 16; wfull=1 after the 16th edge;
  - walmost_full=1 from the edge where wcount=12 (afull_thresh=12).
- While full, pulse winc for 3 cycles:
  - wptr stays at Gray(16)=5'b11000;
  - wovf=1 and stays set;
  - ovf_clr together with winc keeps wovf=1; ovf_clr alone clears it.
- From full, drive wq2_rptr=Gray(1)=5'b00001:
  - wfull=0 and wcount=15 after the next edge;
  - one write then sets wfull again.
- Wrap-around: alternate writes with advancing wq2_rptr past pointer 31→0:
  - wptr goes Gray(31)=5'b10000 → 5'b00000;
  - wptr changes one bit per step; wcount stays correct throughout.
- Thresholds: afull_thresh=0 → walmost_full=1 when empty; afull_thresh=17 → walmost_full never set, even when full.
- Assert wrst_n=0 between edges at wcount=9:
  - all outputs go to 0 immediately, without a clock edge;
  - the first write after release gives waddr=1 and wcount=1.
